// File: rtl/p_hit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p_hit_pkg
// Description : Shared fixed-point types and helpers for the p_hit pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package p_hit_pkg;

    // Default number of fractional bits for Q16.16 operands
    localparam int unsigned Q_BITS_DEF = 16;
    localparam int unsigned FX_W       = 32;

    // Signed fixed-point scalar and a packed 3-vector [z,y,x] (x in bits 31:0)
    typedef logic signed [FX_W-1:0] fx_t;
    typedef fx_t [2:0]              vec3_t;

    // Full-precision signed product, arithmetic (floor) shift, truncated to 32 bits
    function automatic fx_t fx_mul(input fx_t a, input fx_t b, input int unsigned q = Q_BITS_DEF);
        logic signed [2*FX_W-1:0] prod;
        prod = (2*FX_W)'(a) * (2*FX_W)'(b);
        return fx_t'(prod >>> q);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_array.sv
`default_nettype none
// ============================================================================
// Module      : fifo_array
// Description : LANES parallel show-ahead FIFOs sharing one write and one read
//               enable. Writes while full and reads while empty are ignored.
//               Head data reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_array #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 1,
    parameter int unsigned DEPTH = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr_en_i,
    input  logic [LANES-1:0][WIDTH-1:0] din_i,
    output logic                        full_o,
    input  logic                        rd_en_i,
    output logic [LANES-1:0][WIDTH-1:0] dout_o,
    output logic                        empty_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [LANES-1:0] w_full;
    logic [LANES-1:0] w_empty;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0] wr_ptr_q;
        logic [PTR_W-1:0] rd_ptr_q;
        logic [CNT_W-1:0] count_q;
        logic             w_wr;
        logic             w_rd;

        assign w_full[g]  = (count_q == CNT_W'(DEPTH));
        assign w_empty[g] = (count_q == '0);
        assign w_wr       = wr_en_i && !w_full[g];
        assign w_rd       = rd_en_i && !w_empty[g];

        // Pointer and occupancy bookkeeping; reset flushes the lane
        always_ff @(posedge clock) begin
            if (reset) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (w_wr) begin
                    wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
                end
                if (w_rd) begin
                    rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
                end
                case ({w_wr, w_rd})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end

        // Storage array, written only on accepted pushes
        always_ff @(posedge clock) begin
            if (w_wr) begin
                mem_q[wr_ptr_q] <= din_i[g];
            end
        end

        assign dout_o[g] = w_empty[g] ? '0 : mem_q[rd_ptr_q];
    end

    assign full_o  = |w_full;
    assign empty_o = |w_empty;

endmodule
`default_nettype wire

// File: rtl/p_hit_point_lane.sv
`default_nettype none
// ============================================================================
// Module      : p_hit_point_lane
// Description : One axis of the hit-point datapath: captures origin/dir on
//               issue, then computes origin + floor(t*dir >> Q_BITS).
// Revision    : 1.0 - initial release
// ============================================================================
module p_hit_point_lane
    import p_hit_pkg::*;
#(
    parameter int unsigned Q_BITS = Q_BITS_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  fx_t  origin_i,
    input  fx_t  dir_i,
    input  fx_t  t1_i,
    output fx_t  sum_o
);

    fx_t origin_q;
    fx_t dir_q;
    fx_t sum_d;
    fx_t sum_q;

    // Stage 1: capture the ray component on the issue cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            origin_q <= '0;
            dir_q    <= '0;
        end else if (load_i) begin
            origin_q <= origin_i;
            dir_q    <= dir_i;
        end
    end

    // Stage 2 next value: wrapping add of origin and the scaled product
    always_comb begin
        sum_d = origin_q + fx_mul(t1_i, dir_q, Q_BITS);
    end

    // Stage 2 register; validity is tracked by the parent
    always_ff @(posedge clock) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule
`default_nettype wire

// File: rtl/p_hit_point.sv
`default_nettype none
// ============================================================================
// Module      : p_hit_point
// Description : Pairs each ray-plane distance t with its queued ray and
//               produces P = origin + t*dir plus a front-facing flag into an
//               output FIFO. A credit counter covering in-flight and stored
//               results keeps the output FIFO from ever overflowing.
// Revision    : 1.0 - initial release
// ============================================================================
module p_hit_point
    import p_hit_pkg::*;
#(
    parameter int unsigned Q_BITS    = Q_BITS_DEF,
    parameter int unsigned RAY_DEPTH = 16,
    parameter int unsigned OUT_DEPTH = 16
) (
    input  logic  clock,
    input  logic  reset,
    input  vec3_t origin_i,
    input  vec3_t dir_i,
    input  logic  ray_wr_en_i,
    output logic  ray_full_o,
    input  fx_t   t_i,
    input  logic  t_empty_i,
    output logic  t_rd_en_o,
    output vec3_t p_hit_o,
    output logic  p_front_o,
    output logic  out_empty_o,
    input  logic  out_rd_en_i
);

    localparam int unsigned CR_W  = $clog2(OUT_DEPTH + 1);
    localparam int unsigned OUT_W = 3 * FX_W + 1;

    logic [5:0][FX_W-1:0]  w_ray_din;
    logic [5:0][FX_W-1:0]  w_ray_dout;
    logic                  w_ray_empty;
    logic [0:0][OUT_W-1:0] w_out_din;
    logic [0:0][OUT_W-1:0] w_out_dout;
    logic                  w_out_full;
    logic                  w_out_empty;
    logic                  w_fire;
    logic                  w_pop;
    logic [CR_W-1:0]       credit_q;
    logic [CR_W-1:0]       credit_d;
    logic                  v1_q;
    logic                  v2_q;
    logic                  front2_q;
    fx_t                   t1_q;
    vec3_t                 w_sum;

    // Lanes 2:0 carry origin x/y/z, lanes 5:3 carry dir x/y/z
    assign w_ray_din = {dir_i, origin_i};

    fifo_array #(
        .WIDTH (FX_W),
        .LANES (6),
        .DEPTH (RAY_DEPTH)
    ) u_ray_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en_i (ray_wr_en_i),
        .din_i   (w_ray_din),
        .full_o  (ray_full_o),
        .rd_en_i (w_fire),
        .dout_o  (w_ray_dout),
        .empty_o (w_ray_empty)
    );

    // Issue only when both a t and a ray are present and a result slot is reserved.
    // The output-full term is redundant with the credit limit and kept as a guard.
    assign w_fire    = !reset && !t_empty_i && !w_ray_empty && !w_out_full
                       && (credit_q < CR_W'(OUT_DEPTH));
    assign w_pop     = out_rd_en_i && !w_out_empty;
    assign t_rd_en_o = w_fire;

    // Credit next state: issue reserves a slot, a real pop releases one
    always_comb begin
        credit_d = credit_q;
        if (w_fire && !w_pop) begin
            credit_d = credit_q + 1'b1;
        end else if (!w_fire && w_pop) begin
            credit_d = credit_q - 1'b1;
        end
    end

    // Credit register
    always_ff @(posedge clock) begin
        if (reset) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    // Stage 1: capture t and mark the slot valid on an issue cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q <= 1'b0;
            t1_q <= '0;
        end else begin
            v1_q <= w_fire;
            if (w_fire) begin
                t1_q <= t_i;
            end
        end
    end

    // Stage 2: propagate valid and compute the front flag (t strictly positive)
    always_ff @(posedge clock) begin
        if (reset) begin
            v2_q     <= 1'b0;
            front2_q <= 1'b0;
        end else begin
            v2_q     <= v1_q;
            front2_q <= ($signed(t1_q) > 32'sd0);
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_axis
        p_hit_point_lane #(
            .Q_BITS (Q_BITS)
        ) u_lane (
            .clock    (clock),
            .reset    (reset),
            .load_i   (w_fire),
            .origin_i (w_ray_dout[g]),
            .dir_i    (w_ray_dout[g+3]),
            .t1_i     (t1_q),
            .sum_o    (w_sum[g])
        );
    end

    assign w_out_din[0] = {w_sum, front2_q};

    fifo_array #(
        .WIDTH (OUT_W),
        .LANES (1),
        .DEPTH (OUT_DEPTH)
    ) u_out_fifo (
        .clock   (clock),
        .reset   (reset),
        .wr_en_i (v2_q),
        .din_i   (w_out_din),
        .full_o  (w_out_full),
        .rd_en_i (out_rd_en_i),
        .dout_o  (w_out_dout),
        .empty_o (w_out_empty)
    );

    assign p_hit_o     = w_out_dout[0][OUT_W-1:1];
    assign p_front_o   = w_out_dout[0][0];
    assign out_empty_o = w_out_empty;

endmodule
`default_nettype wire
